// File: rtl/motor_ticks_poller.sv
// motor_ticks_poller: periodic left/right tick sampler with ready timeouts.
// Define TICKS_DELTA_EN to build the per-period delta outputs.
module motor_ticks_poller #(
  parameter int G_CLK_FREQ_MHZ = 12,
  parameter int G_POLL_US      = 20000,
  parameter int G_TIMEOUT_US   = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic        get_motor_ticks_left_o,
  output logic        get_motor_ticks_rght_o,
  input  logic        motor_ticks_left_rdy_i,
  input  logic        motor_ticks_rght_rdy_i,
  input  logic [31:0] motor_ticks_left_i,
  input  logic [31:0] motor_ticks_rght_i,
  output logic [31:0] ticks_left_o,
  output logic [31:0] ticks_rght_o,
  output logic [31:0] dticks_left_o,
  output logic [31:0] dticks_rght_o,
  output logic        sample_vld_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  localparam int PER = G_CLK_FREQ_MHZ * G_POLL_US;
  localparam int TOC = G_CLK_FREQ_MHZ * G_TIMEOUT_US;
  localparam int PW  = $clog2(PER + 1);
  localparam int TW  = $clog2(TOC + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_L,
    WAIT_L,
    REQ_R,
    WAIT_R,
    UPD
  } state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   hold_l;
  logic          tick;
  logic          to_hit;
  logic          take_r;

  assign tick   = (pcnt == PW'(PER - 1));
  // tcnt counts cycles since the get pulse
  assign to_hit = (tcnt >= TW'(TOC - 1));
  assign take_r = (state == WAIT_R) && motor_ticks_rght_rdy_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      pcnt                   <= '0;
      tcnt                   <= '0;
      hold_l                 <= '0;
      get_motor_ticks_left_o <= 1'b0;
      get_motor_ticks_rght_o <= 1'b0;
      ticks_left_o           <= '0;
      ticks_rght_o           <= '0;
      sample_vld_o           <= 1'b0;
      timeout_o              <= 1'b0;
      overrun_o              <= 1'b0;
    end else begin
      pcnt                   <= tick ? '0 : pcnt + PW'(1);
      get_motor_ticks_left_o <= 1'b0;
      get_motor_ticks_rght_o <= 1'b0;
      sample_vld_o           <= 1'b0;
      overrun_o              <= tick && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (tick && en_i) begin
            state                  <= REQ_L;
            get_motor_ticks_left_o <= 1'b1;
          end
        end
        REQ_L: begin
          state <= WAIT_L;
          tcnt  <= TW'(1);
        end
        WAIT_L: begin
          if (motor_ticks_left_rdy_i) begin
            hold_l                 <= motor_ticks_left_i;
            state                  <= REQ_R;
            get_motor_ticks_rght_o <= 1'b1;
          end else if (to_hit) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        REQ_R: begin
          state <= WAIT_R;
          tcnt  <= TW'(1);
        end
        WAIT_R: begin
          if (take_r) begin
            ticks_left_o <= hold_l;
            ticks_rght_o <= motor_ticks_rght_i;
            sample_vld_o <= 1'b1;
            timeout_o    <= 1'b0;
            state        <= UPD;
          end else if (to_hit) begin
            state     <= IDLE;
            timeout_o <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        UPD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TICKS_DELTA_EN
  logic first;

  // ticks_*_o still hold the previous sample when take_r fires
  always_ff @(posedge clk) begin
    if (rst) begin
      first         <= 1'b1;
      dticks_left_o <= '0;
      dticks_rght_o <= '0;
    end else if (take_r) begin
      first         <= 1'b0;
      dticks_left_o <= first ? '0 : hold_l - ticks_left_o;
      dticks_rght_o <= first ? '0 :
                       motor_ticks_rght_i - ticks_rght_o;
    end
  end
`else
  assign dticks_left_o = '0;
  assign dticks_rght_o = '0;
`endif

endmodule

// File: tb/tb_motor_ticks_poller.sv
// tb_motor_ticks_poller: vector table plus scoreboard for the poller.
// A second instance with a long timeout exercises overrun.
module tb_motor_ticks_poller;

`ifdef TICKS_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en1, rdyl1, rdyr1;
  logic [31:0] dl1, dr1;
  logic        gl1, gr1, vld1, to1, ov1;
  logic [31:0] tl1, tr1, ddl1, ddr1;
  logic        en2, rdyl2, rdyr2;
  logic [31:0] dl2, dr2;
  logic        gl2, gr2, vld2, to2, ov2;
  logic [31:0] tl2, tr2, ddl2, ddr2;

  motor_ticks_poller #(
    .G_CLK_FREQ_MHZ(1), .G_POLL_US(100), .G_TIMEOUT_US(30)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en1),
    .get_motor_ticks_left_o(gl1),
    .get_motor_ticks_rght_o(gr1),
    .motor_ticks_left_rdy_i(rdyl1),
    .motor_ticks_rght_rdy_i(rdyr1),
    .motor_ticks_left_i(dl1),
    .motor_ticks_rght_i(dr1),
    .ticks_left_o(tl1), .ticks_rght_o(tr1),
    .dticks_left_o(ddl1), .dticks_rght_o(ddr1),
    .sample_vld_o(vld1), .timeout_o(to1),
    .overrun_o(ov1)
  );

  motor_ticks_poller #(
    .G_CLK_FREQ_MHZ(1), .G_POLL_US(100), .G_TIMEOUT_US(200)
  ) dut_ov (
    .clk(clk), .rst(rst), .en_i(en2),
    .get_motor_ticks_left_o(gl2),
    .get_motor_ticks_rght_o(gr2),
    .motor_ticks_left_rdy_i(rdyl2),
    .motor_ticks_rght_rdy_i(rdyr2),
    .motor_ticks_left_i(dl2),
    .motor_ticks_rght_i(dr2),
    .ticks_left_o(tl2), .ticks_rght_o(tr2),
    .dticks_left_o(ddl2), .dticks_rght_o(ddr2),
    .sample_vld_o(vld2), .timeout_o(to2),
    .overrun_o(ov2)
  );

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          dl;
    int          dr;
    bit          stray;
    bit          to_b;
    logic [31:0] edl;
    logic [31:0] edr;
  } vec_t;

  typedef struct {
    logic [31:0] tl;
    logic [31:0] tr;
    logic [31:0] dl;
    logic [31:0] dr;
  } exp_t;

  vec_t tbl [7];
  exp_t sb [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ngl1 = 0, ngl2 = 0, nov1 = 0, nov2 = 0;
  int   nvld1 = 0, nexp1 = 0, ovc2 = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (gl1) ngl1++;
      if (gl2) ngl2++;
      if (ov1) nov1++;
      if (ov2) begin nov2++; ovc2 = cyc; end
      if (vld1) nvld1++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ed(input logic [31:0] d);
    return DELTA ? d : 32'h0;
  endfunction

  function automatic bit sel_val(input int sel);
    case (sel)
      0: return gl1;
      1: return gr1;
      2: return vld1;
      3: return to1;
      4: return gl2;
      5: return gr2;
      6: return vld2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int bound,
                          output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int n = 0; n <= bound; n++) begin
      if (n != 0) @(negedge clk);
      if (sel_val(sel)) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_sel%0d act=none exp=event in %0d",
               sel, bound);
    end
  endtask

  task automatic run_row(input vec_t v, output int gl);
    int   gr, t;
    bit   ok;
    exp_t e;
    wait_for(0, 150, gl, ok);
    if (!ok) return;
    check("get_l_phase", 32'(gl % 100), 32'd0);
    check("to_before", {31'd0, to1}, {31'd0, v.to_b});
    if (v.dl < 0) begin
      wait_for(3, 40, t, ok);
      if (ok) check("to_l_lat", 32'(t - gl), 32'd30);
      return;
    end
    repeat (v.dl) @(negedge clk);
    rdyl1 = 1'b1;
    dl1 = v.l;
    @(negedge clk);
    rdyl1 = 1'b0;
    dl1 = 32'h0;
    wait_for(1, 5, gr, ok);
    if (!ok) return;
    check("get_r_lat", 32'(gr - gl), 32'(v.dl + 1));
    if (v.dr < 0) begin
      wait_for(3, 40, t, ok);
      if (ok) check("to_r_lat", 32'(t - gr), 32'd30);
      return;
    end
    if (v.stray) begin
      @(negedge clk);
      rdyl1 = 1'b1;
      dl1 = 32'hDEADBEEF;
      @(negedge clk);
      rdyl1 = 1'b0;
      dl1 = 32'h0;
      repeat (v.dr - 2) @(negedge clk);
    end else begin
      repeat (v.dr) @(negedge clk);
    end
    rdyr1 = 1'b1;
    dr1 = v.r;
    sb.push_back('{v.l, v.r, ed(v.edl), ed(v.edr)});
    nexp1++;
    @(negedge clk);
    rdyr1 = 1'b0;
    dr1 = 32'h0;
    wait_for(2, 5, t, ok);
    if (!ok) return;
    check("vld_lat", 32'(t - gr), 32'(v.dr + 1));
    e = sb.pop_front();
    check("ticks_l", tl1, e.tl);
    check("ticks_r", tr1, e.tr);
    check("dticks_l", ddl1, e.dl);
    check("dticks_r", ddr1, e.dr);
    check("to_clr", {31'd0, to1}, 32'd0);
    @(negedge clk);
    check("vld_pulse", {31'd0, vld1}, 32'd0);
    check("ticks_hold", tr1, e.tr);
  endtask

  initial begin
    int   g, t;
    bit   ok;
    vec_t rv;
    tbl[0] = '{32'd100, 32'hFFFFFFCE, 5, 5, 1'b0, 1'b0,
               32'h0, 32'h0};
    tbl[1] = '{32'd150, 32'h7FFFFFF0, 3, 7, 1'b0, 1'b0,
               32'd50, 32'h80000022};
    tbl[2] = '{32'd200, 32'h7FFFFFFF, 1, 6, 1'b1, 1'b0,
               32'd50, 32'd15};
    tbl[3] = '{32'h0, 32'h0, -1, 0, 1'b0, 1'b0,
               32'h0, 32'h0};
    tbl[4] = '{32'hFFFFFFF6, 32'h80000005, 29, 29, 1'b0, 1'b1,
               32'hFFFFFF2E, 32'd6};
    tbl[5] = '{32'd7, 32'h0, 4, -1, 1'b0, 1'b0,
               32'h0, 32'h0};
    tbl[6] = '{32'd5, 32'h80000005, 2, 2, 1'b0, 1'b1,
               32'd15, 32'h0};
    rv = '{32'd300, 32'd400, 5, 5, 1'b0, 1'b0, 32'h0, 32'h0};

    rst = 1'b1;
    en1 = 1'b0; rdyl1 = 1'b0; rdyr1 = 1'b0;
    dl1 = 32'h0; dr1 = 32'h0;
    en2 = 1'b1; rdyl2 = 1'b0; rdyr2 = 1'b0;
    dl2 = 32'h0; dr2 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ticks", tl1 | tr1 | tl2 | tr2, 32'h0);
    check("rst_dticks", ddl1 | ddr1 | ddl2 | ddr2, 32'h0);
    check("rst_flags",
          {22'd0, gl1, gr1, vld1, to1, ov1,
           gl2, gr2, vld2, to2, ov2}, 32'h0);
    rst = 1'b0;

    wait_for(4, 150, g, ok);
    check("ov_get_l", 32'(g), 32'd100);
    repeat (120) @(negedge clk);
    rdyl2 = 1'b1;
    dl2 = 32'h11;
    @(negedge clk);
    rdyl2 = 1'b0;
    wait_for(5, 5, g, ok);
    check("ov_get_r", 32'(g), 32'd221);
    repeat (5) @(negedge clk);
    rdyr2 = 1'b1;
    dr2 = 32'h22;
    @(negedge clk);
    rdyr2 = 1'b0;
    wait_for(6, 5, g, ok);
    check("ov_vld", 32'(g), 32'd227);
    check("ov_ticks", {tl2[15:0], tr2[15:0]}, 32'h00110022);
    check("ov_count", 32'(nov2), 32'd1);
    check("ov_cycle", 32'(ovc2), 32'd200);
    check("ov_no_extra_get", 32'(ngl2), 32'd1);
    check("ov_no_to", {31'd0, to2}, 32'd0);
    en2 = 1'b0;

    while (cyc < 350) @(negedge clk);
    check("en0_no_get", 32'(ngl1), 32'd0);
    en1 = 1'b1;

    for (int i = 0; i < 7; i++) run_row(tbl[i], g);

    wait_for(0, 150, g, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ticks", tl1 | tr1 | ddl1 | ddr1, 32'h0);
    check("mid_rst_flags",
          {27'd0, gl1, gr1, vld1, to1, ov1}, 32'h0);
    rst = 1'b0;
    run_row(rv, g);
    check("post_rst_get_l", 32'(g), 32'd100);

    check("no_overrun", 32'(nov1), 32'd0);
    check("vld_count", 32'(nvld1), 32'(nexp1));
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
